// File: rtl/note_scan_disp.sv
// Note display driver: encodes per-octave note codes to 7-segment patterns and
// drives a multiplexed digit display in priority (highest octave) or scan mode.
module note_scan_disp #(
    parameter int unsigned NUM_OCT     = 3,
    parameter int unsigned NUM_DIG     = 6,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned DIG_ACT_LOW = 1,
    parameter int unsigned SEG_ACT_LOW = 0,
    localparam int unsigned OW = (NUM_OCT > 1) ? $clog2(NUM_OCT) : 1
) (
    input  logic                   clk_1mhz,
    input  logic                   rst,
    input  logic [4*NUM_OCT-1:0]   note_in,
    input  logic                   mode,
    input  logic                   blank,
    output logic [NUM_DIG-1:0]     dig,
    output logic [7:0]             seg,
    output logic                   note_valid,
    output logic [OW-1:0]          cur_oct
);

    localparam int unsigned SW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [NUM_DIG-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};
    localparam logic [7:0]         SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    // Active-high pattern; anything that is not a note 1..7 shows the rest dash
    function automatic logic [7:0] seg_pat(input logic [3:0] code);
        case (code)
            4'd1:    seg_pat = 8'h60;
            4'd2:    seg_pat = 8'hDA;
            4'd3:    seg_pat = 8'hF2;
            4'd4:    seg_pat = 8'h66;
            4'd5:    seg_pat = 8'hB6;
            4'd6:    seg_pat = 8'hBE;
            4'd7:    seg_pat = 8'hE0;
            default: seg_pat = 8'h02;
        endcase
    endfunction

    function automatic logic [NUM_DIG-1:0] dig_on(input logic [SW-1:0] idx);
        dig_on = (NUM_DIG'(1) << idx) ^ DIG_OFF;
    endfunction

    logic [4*NUM_OCT-1:0] note_q;
    logic                 mode_q;
    logic                 hold_vld, hold_vld_n;
    logic [OW-1:0]        hold_ch, hold_ch_n;
    logic [3:0]           hold_code, hold_code_n;
    logic [PW-1:0]        presc, presc_n;
    logic [SW-1:0]        slot, slot_n;
    logic                 deghost, deghost_n;
    logic [NUM_DIG-1:0]   dig_n;
    logic [7:0]           seg_n;
    logic                 note_valid_n;
    logic [OW-1:0]        cur_oct_n;

    logic                 win;
    logic [OW-1:0]        win_ch;
    logic [3:0]           win_code;
    logic                 scan_in_range;
    logic [3:0]           scan_code;

    // Highest valid channel wins; the digit under the scan slot picks its channel
    always_comb begin
        win           = 1'b0;
        win_ch        = '0;
        win_code      = '0;
        scan_in_range = 1'b0;
        scan_code     = '0;
        for (int k = 0; k < int'(NUM_OCT); k++) begin
            if (note_q[4*k +: 4] != 4'd0 && !note_q[4*k+3]) begin
                win      = 1'b1;
                win_ch   = OW'(k);
                win_code = note_q[4*k +: 4];
            end
            if (SW'(k) == slot) begin
                scan_in_range = 1'b1;
                scan_code     = note_q[4*k +: 4];
            end
        end
    end

    always_comb begin
        hold_vld_n   = hold_vld;
        hold_ch_n    = hold_ch;
        hold_code_n  = hold_code;
        presc_n      = presc;
        slot_n       = slot;
        deghost_n    = 1'b0;
        dig_n        = dig;
        seg_n        = seg;
        note_valid_n = note_valid;
        cur_oct_n    = cur_oct;

        // Scan timebase restarts on a mode change; otherwise free-runs
        if (mode != mode_q) begin
            presc_n = '0;
            slot_n  = '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc_n   = '0;
            slot_n    = (slot == SW'(NUM_DIG - 1)) ? '0 : slot + SW'(1);
            deghost_n = 1'b1;
        end else begin
            presc_n = presc + PW'(1);
        end

        if (mode != mode_q || blank) begin
            dig_n        = DIG_OFF;
            seg_n        = SEG_OFF;
            note_valid_n = 1'b0;
        end else if (!mode_q) begin
            if (win) begin
                hold_vld_n   = 1'b1;
                hold_ch_n    = win_ch;
                hold_code_n  = win_code;
                dig_n        = dig_on(SW'(win_ch));
                seg_n        = seg_pat(win_code) ^ SEG_OFF;
                note_valid_n = 1'b1;
                cur_oct_n    = win_ch;
            end else if (hold_vld) begin
                // Stale note: dp marks it as no longer live
                dig_n        = dig_on(SW'(hold_ch));
                seg_n        = (seg_pat(hold_code) | 8'h01) ^ SEG_OFF;
                note_valid_n = 1'b0;
                cur_oct_n    = hold_ch;
            end else begin
                dig_n        = DIG_OFF;
                seg_n        = SEG_OFF;
                note_valid_n = 1'b0;
            end
        end else begin
            note_valid_n = 1'b0;
            cur_oct_n    = '0;
            if (deghost) begin
                dig_n = DIG_OFF;
            end else begin
                dig_n = dig_on(slot);
                seg_n = scan_in_range ? (seg_pat(scan_code) ^ SEG_OFF) : SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            note_q     <= '0;
            mode_q     <= 1'b0;
            hold_vld   <= 1'b0;
            hold_ch    <= '0;
            hold_code  <= '0;
            presc      <= '0;
            slot       <= '0;
            deghost    <= 1'b0;
            dig        <= DIG_OFF;
            seg        <= SEG_OFF;
            note_valid <= 1'b0;
            cur_oct    <= '0;
        end else begin
            note_q     <= note_in;
            mode_q     <= mode;
            hold_vld   <= hold_vld_n;
            hold_ch    <= hold_ch_n;
            hold_code  <= hold_code_n;
            presc      <= presc_n;
            slot       <= slot_n;
            deghost    <= deghost_n;
            dig        <= dig_n;
            seg        <= seg_n;
            note_valid <= note_valid_n;
            cur_oct    <= cur_oct_n;
        end
    end

endmodule

// File: tb/tb_note_scan_disp.sv
// Directed bench for note_scan_disp: priority, hold, scan, blank, mode switch, reset.
module tb_note_scan_disp;

    logic        clk_1mhz = 1'b0;
    logic        rst;
    logic [11:0] note_in;
    logic        mode;
    logic        blank;
    logic [5:0]  dig;
    logic [7:0]  seg;
    logic        note_valid;
    logic [1:0]  cur_oct;

    int checks   = 0;
    int failures = 0;

    note_scan_disp #(
        .NUM_OCT(3), .NUM_DIG(6), .SCAN_DIV(4), .DIG_ACT_LOW(1), .SEG_ACT_LOW(0)
    ) dut (
        .clk_1mhz(clk_1mhz), .rst(rst), .note_in(note_in), .mode(mode), .blank(blank),
        .dig(dig), .seg(seg), .note_valid(note_valid), .cur_oct(cur_oct)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1mhz);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] ed, input logic [7:0] es,
                              input logic env, input logic [1:0] eco);
        chk({tag, ".dig"}, 32'(dig), 32'(ed));
        chk({tag, ".seg"}, 32'(seg), 32'(es));
        chk({tag, ".nv"}, 32'(note_valid), 32'(env));
        chk({tag, ".oct"}, 32'(cur_oct), 32'(eco));
        chk({tag, ".onehot"}, 32'($countones(~dig) <= 1), 32'd1);
    endtask

    logic [7:0] pat_tab [6];
    logic [7:0] prev_seg;
    logic [5:0] ed;
    logic [7:0] es;
    int         s;
    logic       dk;

    initial begin
        rst = 1'b1; note_in = '0; mode = 1'b0; blank = 1'b0;
        tick(); tick();
        expect_out("reset", 6'b111111, 8'h00, 1'b0, 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("idle", 6'b111111, 8'h00, 1'b0, 2'd0);
        end

        // Priority: two-clock latency, highest channel wins
        note_in = {4'd3, 4'd5, 4'd1};
        tick();
        expect_out("prio_lat", 6'b111111, 8'h00, 1'b0, 2'd0);
        tick();
        expect_out("prio_ch2", 6'b111011, 8'hF2, 1'b1, 2'd2);
        note_in = {4'd0, 4'd5, 4'd1};
        tick(); tick();
        expect_out("prio_ch1", 6'b111101, 8'hB6, 1'b1, 2'd1);

        // Hold and stale dp
        note_in = {4'd0, 4'd0, 4'd7};
        tick(); tick();
        expect_out("prio_ch0", 6'b111110, 8'hE0, 1'b1, 2'd0);
        note_in = '0;
        tick(); tick();
        expect_out("hold", 6'b111110, 8'hE1, 1'b0, 2'd0);
        note_in = {4'd0, 4'd9, 4'd0};
        tick(); tick();
        expect_out("hold_inv", 6'b111110, 8'hE1, 1'b0, 2'd0);

        // Reset mid-hold discards the held note
        note_in = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("rst_hold", 6'b111111, 8'h00, 1'b0, 2'd0);
        tick(); tick();
        expect_out("rst_nohold", 6'b111111, 8'h00, 1'b0, 2'd0);

        // Scan mode with a blank pulse at cycles 30..32
        pat_tab[0] = 8'h66; pat_tab[1] = 8'hDA; pat_tab[2] = 8'h02;
        pat_tab[3] = 8'h00; pat_tab[4] = 8'h00; pat_tab[5] = 8'h00;
        note_in = {4'd0, 4'd2, 4'd4};
        mode = 1'b1;
        tick();
        expect_out("scan_chg", 6'b111111, 8'h00, 1'b0, 2'd0);
        prev_seg = 8'h00;
        for (int c = 1; c <= 40; c++) begin
            blank = (c >= 30 && c <= 32);
            tick();
            if (c <= 4) begin
                s = 0; dk = 1'b0;
            end else begin
                s = (1 + (c - 5) / 4) % 6;
                dk = ((c - 5) % 4 == 0);
            end
            if (blank) begin
                ed = 6'b111111; es = 8'h00;
            end else if (dk) begin
                ed = 6'b111111; es = prev_seg;
            end else begin
                ed = ~(6'b000001 << s); es = pat_tab[s];
            end
            prev_seg = es;
            expect_out($sformatf("scan_c%0d", c), ed, es, 1'b0, 2'd0);
        end
        blank = 1'b0;

        // Mode toggle mid-slot: dark clocks, then scan restarts at slot 0
        mode = 1'b0;
        tick();
        expect_out("tog_off", 6'b111111, 8'h00, 1'b0, 2'd0);
        mode = 1'b1;
        tick();
        expect_out("tog_on", 6'b111111, 8'h00, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("tog_slot0", 6'b111110, 8'h66, 1'b0, 2'd0);
        end
        tick();
        expect_out("tog_deghost", 6'b111111, 8'h66, 1'b0, 2'd0);
        tick();
        expect_out("tog_slot1", 6'b111101, 8'hDA, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
